// File: rtl/spd_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spd_ramp_ctrl
// Brief    : Slew-rate limiter and controlled-stop sequencer for the signed
//            left/right motor speed commands.
// Revision : 1.0 - initial release
// ============================================================================
module spd_ramp_ctrl #(
    parameter int TICK_DIV  = 2048,
    parameter int STEP      = 8,
    parameter int STOP_STEP = 32,
    parameter int SPD_LIM   = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               stop,
    input  logic signed [10:0] lft_tgt,
    input  logic signed [10:0] rght_tgt,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd,
    output logic               tick,
    output logic               settled,
    output logic               halted
);

    localparam int                   c_CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX   = c_CNT_W'(TICK_DIV - 1);
    localparam logic signed [11:0]   c_LIM_P     = 12'(SPD_LIM);
    localparam logic signed [11:0]   c_LIM_N     = -c_LIM_P;
    localparam logic signed [11:0]   c_STEP      = 12'(STEP);
    localparam logic signed [11:0]   c_STOP_STEP = 12'(STOP_STEP);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_RUN      = 2'd1;
    localparam logic [1:0] c_ST_STOPPING = 2'd2;
    localparam logic [1:0] c_ST_HALT     = 2'd3;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_state;
    logic signed [10:0]   r_lft;
    logic signed [10:0]   r_rght;
    logic                 r_settled;
    logic                 r_halted;

    logic                 w_tick;
    logic signed [10:0]   w_tc_l;
    logic signed [10:0]   w_tc_r;
    logic [1:0]           w_pre_next;
    logic [1:0]           w_ramp_state;
    logic [1:0]           w_next_state;
    logic signed [10:0]   w_eff_l;
    logic signed [10:0]   w_eff_r;
    logic signed [11:0]   w_step;
    logic signed [10:0]   w_new_l;
    logic signed [10:0]   w_new_r;
    logic                 w_outs_zero;

    function automatic logic signed [10:0] clamp_tgt(input logic signed [10:0] t);
        logic signed [11:0] t12;
        t12 = {t[10], t};
        if (t12 > c_LIM_P)
            return c_LIM_P[10:0];
        else if (t12 < c_LIM_N)
            return c_LIM_N[10:0];
        else
            return t;
    endfunction

    // Difference is taken at 12 bits so a full-scale reversal cannot wrap.
    function automatic logic signed [10:0] ramp_to(input logic signed [10:0] cur,
                                                   input logic signed [10:0] eff,
                                                   input logic signed [11:0] s);
        logic signed [11:0] d;
        logic signed [11:0] ad;
        d  = {eff[10], eff} - {cur[10], cur};
        ad = (d < 0) ? -d : d;
        if (ad <= s)
            return eff;
        else if (d > 0)
            return cur + s[10:0];
        else
            return cur - s[10:0];
    endfunction

    assign w_tick      = (r_cnt == c_CNT_MAX);
    assign w_outs_zero = (r_lft == 11'sd0) && (r_rght == 11'sd0);

    always_comb begin
        w_tc_l     = clamp_tgt(lft_tgt);
        w_tc_r     = clamp_tgt(rght_tgt);
        w_pre_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (stop)
                    w_pre_next = w_outs_zero ? c_ST_HALT : c_ST_STOPPING;
                else if (en)
                    w_pre_next = c_ST_RUN;
                else
                    w_pre_next = c_ST_IDLE;
            end
            c_ST_RUN: begin
                if (stop)
                    w_pre_next = c_ST_STOPPING;
                else if (!en)
                    w_pre_next = c_ST_IDLE;
                else
                    w_pre_next = c_ST_RUN;
            end
            c_ST_STOPPING: w_pre_next = c_ST_STOPPING;
            default: begin
                if (!stop && !en)
                    w_pre_next = c_ST_IDLE;
                else
                    w_pre_next = c_ST_HALT;
            end
        endcase

        // The ramp follows the state being entered; only the final stop step
        // keeps the stopping slope, since HALT is decided after the update.
        w_ramp_state = (r_state == c_ST_STOPPING) ? c_ST_STOPPING : w_pre_next;
        w_eff_l      = (w_ramp_state == c_ST_RUN) ? w_tc_l : 11'sd0;
        w_eff_r      = (w_ramp_state == c_ST_RUN) ? w_tc_r : 11'sd0;
        w_step       = (w_ramp_state == c_ST_STOPPING) ? c_STOP_STEP : c_STEP;
        w_new_l      = ramp_to(r_lft, w_eff_l, w_step);
        w_new_r      = ramp_to(r_rght, w_eff_r, w_step);

        if (r_state == c_ST_STOPPING && w_new_l == 11'sd0 && w_new_r == 11'sd0)
            w_next_state = c_ST_HALT;
        else
            w_next_state = w_pre_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_state   <= c_ST_IDLE;
            r_lft     <= 11'sd0;
            r_rght    <= 11'sd0;
            r_settled <= 1'b1;
            r_halted  <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_state   <= w_next_state;
                r_lft     <= w_new_l;
                r_rght    <= w_new_r;
                r_settled <= (w_new_l == w_eff_l) && (w_new_r == w_eff_r);
                r_halted  <= (w_next_state == c_ST_HALT);
            end
        end
    end

    assign lft_spd  = r_lft;
    assign rght_spd = r_rght;
    assign tick     = w_tick;
    assign settled  = r_settled;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_spd_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spd_ramp_ctrl
// Brief    : Directed self-checking bench for spd_ramp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spd_ramp_ctrl;

    localparam int c_TICK_DIV = 16;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               stop;
    logic signed [10:0] lft_tgt;
    logic signed [10:0] rght_tgt;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               tick;
    logic               settled;
    logic               halted;

    int checks;
    int errors;

    spd_ramp_ctrl #(
        .TICK_DIV  (c_TICK_DIV),
        .STEP      (8),
        .STOP_STEP (32),
        .SPD_LIM   (1000)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .stop     (stop),
        .lft_tgt  (lft_tgt),
        .rght_tgt (rght_tgt),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .tick     (tick),
        .settled  (settled),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next update edge; a missing tick is a failure.
    task automatic next_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < c_TICK_DIV + 4; i++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tick_timeout: got no tick, need tick within %0d clocks", c_TICK_DIV + 4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; stop = 1'b0; lft_tgt = '0; rght_tgt = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (lft_spd !== 11'sd0 || rght_spd !== 11'sd0 || tick !== 1'b0 ||
            settled !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset: got l=%0d r=%0d tick=%b settled=%b halted=%b, need 0 0 0 1 0",
                     lft_spd, rght_spd, tick, settled, halted);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        int exp_l[5] = '{8, 16, 24, 32, 40};
        int exp_r[5] = '{-8, -16, -20, -20, -20};
        en = 1'b1; lft_tgt = 11'sd40; rght_tgt = -11'sd20;
        for (int k = 0; k < 5; k++) begin
            next_tick();
            checks++;
            if (lft_spd !== 11'(exp_l[k]) || rght_spd !== 11'(exp_r[k])) begin
                errors++;
                $display("FAIL ramp_up[%0d]: got l=%0d r=%0d, need l=%0d r=%0d",
                         k, lft_spd, rght_spd, exp_l[k], exp_r[k]);
            end
            if (k == 0) begin
                repeat (8) @(posedge clk);
                #1;
                checks++;
                if (lft_spd !== 11'sd8 || rght_spd !== -11'sd8) begin
                    errors++;
                    $display("FAIL hold_between_ticks: got l=%0d r=%0d, need l=8 r=-8",
                             lft_spd, rght_spd);
                end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (settled !== (k == 4)) begin
                    errors++;
                    $display("FAIL ramp_up_settled[%0d]: got %b, need %b", k, settled, k == 4);
                end
            end
        end
    endtask

    task automatic test_reversal();
        int exp_l[4] = '{8, 0, -8, -16};
        lft_tgt = 11'sd16;
        ticks(3);
        checks++;
        if (lft_spd !== 11'sd16) begin
            errors++;
            $display("FAIL rev_start: got l=%0d, need 16", lft_spd);
        end
        lft_tgt = -11'sd16;
        for (int k = 0; k < 4; k++) begin
            next_tick();
            checks++;
            if (lft_spd !== 11'(exp_l[k]) || settled !== (k == 3)) begin
                errors++;
                $display("FAIL reversal[%0d]: got l=%0d settled=%b, need l=%0d settled=%b",
                         k, lft_spd, settled, exp_l[k], k == 3);
            end
        end
    endtask

    task automatic test_saturate();
        int prev_l;
        int prev_r;
        int dl;
        int dr;
        lft_tgt = 11'sd1023; rght_tgt = -11'sd1024;
        for (int k = 0; k < 140; k++) begin
            prev_l = int'(lft_spd);
            prev_r = int'(rght_spd);
            next_tick();
            dl = int'(lft_spd) - prev_l;
            dr = int'(rght_spd) - prev_r;
            checks++;
            if (dl > 8 || dl < -8 || dr > 8 || dr < -8 ||
                lft_spd > 11'sd1000 || rght_spd < -11'sd1000) begin
                errors++;
                $display("FAIL sat_bound[%0d]: got l=%0d r=%0d (dl=%0d dr=%0d), need |out|<=1000 |d|<=8",
                         k, lft_spd, rght_spd, dl, dr);
            end
        end
        checks++;
        if (lft_spd !== 11'sd1000 || rght_spd !== -11'sd1000 || settled !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: got l=%0d r=%0d settled=%b, need 1000 -1000 1",
                     lft_spd, rght_spd, settled);
        end
    endtask

    task automatic test_stop();
        int exp_m[4] = '{68, 36, 4, 0};
        lft_tgt = 11'sd100; rght_tgt = -11'sd100;
        ticks(120);
        checks++;
        if (lft_spd !== 11'sd100 || rght_spd !== -11'sd100) begin
            errors++;
            $display("FAIL stop_start: got l=%0d r=%0d, need 100 -100", lft_spd, rght_spd);
        end
        stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_tick();
            checks++;
            if (lft_spd !== 11'(exp_m[k]) || rght_spd !== 11'(-exp_m[k]) || halted !== (k == 3)) begin
                errors++;
                $display("FAIL stopping[%0d]: got l=%0d r=%0d halted=%b, need l=%0d r=%0d halted=%b",
                         k, lft_spd, rght_spd, halted, exp_m[k], -exp_m[k], k == 3);
            end
        end
        stop = 1'b0; en = 1'b1;
        next_tick();
        checks++;
        if (halted !== 1'b1 || lft_spd !== 11'sd0) begin
            errors++;
            $display("FAIL halt_hold: got halted=%b l=%0d, need halted=1 l=0", halted, lft_spd);
        end
        en = 1'b0;
        next_tick();
        checks++;
        if (halted !== 1'b0 || lft_spd !== 11'sd0) begin
            errors++;
            $display("FAIL halt_rearm: got halted=%b l=%0d, need halted=0 l=0", halted, lft_spd);
        end
        en = 1'b1; lft_tgt = 11'sd200; rght_tgt = -11'sd200;
        next_tick();
        checks++;
        if (lft_spd !== 11'sd8 || rght_spd !== -11'sd8 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_to_run: got l=%0d r=%0d halted=%b, need 8 -8 0",
                     lft_spd, rght_spd, halted);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        ticks(24);
        checks++;
        if (lft_spd !== 11'sd200 || rght_spd !== -11'sd200) begin
            errors++;
            $display("FAIL mreset_pre: got l=%0d r=%0d, need 200 -200", lft_spd, rght_spd);
        end
        repeat (5) @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (lft_spd !== 11'sd0 || rght_spd !== 11'sd0 || tick !== 1'b0 || settled !== 1'b1) begin
            errors++;
            $display("FAIL mreset_zero: got l=%0d r=%0d tick=%b settled=%b, need 0 0 0 1",
                     lft_spd, rght_spd, tick, settled);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL mreset_tick_pos: got tick after %0d edges, need 15", n);
        end
        @(posedge clk);
        #1;
        checks++;
        if (lft_spd !== 11'sd8 || rght_spd !== -11'sd8) begin
            errors++;
            $display("FAIL mreset_first: got l=%0d r=%0d, need 8 -8", lft_spd, rght_spd);
        end
    endtask

    task automatic test_stop_priority();
        int exp_m[2] = '{16, 0};
        ticks(5);
        checks++;
        if (lft_spd !== 11'sd48 || rght_spd !== -11'sd48) begin
            errors++;
            $display("FAIL prio_start: got l=%0d r=%0d, need 48 -48", lft_spd, rght_spd);
        end
        en = 1'b0; stop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_tick();
            checks++;
            if (lft_spd !== 11'(exp_m[k]) || rght_spd !== 11'(-exp_m[k]) || halted !== (k == 1)) begin
                errors++;
                $display("FAIL stop_prio[%0d]: got l=%0d r=%0d halted=%b, need l=%0d r=%0d halted=%b",
                         k, lft_spd, rght_spd, halted, exp_m[k], -exp_m[k], k == 1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp_up();
        test_reversal();
        test_saturate();
        test_stop();
        test_mid_reset();
        test_stop_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
